dark_stream_tx: RTL and testbench

// - Raster pixel-stream transmitter feeding the windowed filter stages (3x3 min / dark-channel) of the dehaze pipeline.
// - Accepts pixels from an upstream valid/ready source and emits the valid_out/data_out stream those stages consume.
// - Emits sof/eol/eof markers and HBLANK idle gaps after each line.
// - After the last image row, emits FLUSH_LINES lines of neutral pad pixels (all ones) so downstream line buffers drain the final rows.

---
 rtl/dehaze_pkg.sv | 17 +
 rtl/pix_fifo.sv | 59 +++++
 rtl/dark_stream_tx.sv | 186 ++++++++++++++++++
 tb/tb_dark_stream_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze stream path.
// Transmitter FSM encoding and the neutral pad pixel value.
package dehaze_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_HGAP,
    S_FLUSH,
    S_FGAP,
    S_DONE
  } tx_state_t;

  // All-ones pad pixel; users slice the low DATA_WIDTH bits.
  localparam logic [63:0] PAD_MAX = '1;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous pixel FIFO between the upstream source and the
// transmitter output stage; combinational read of the head entry.
module pix_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; clr empties the FIFO for a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dark_stream_tx.sv
// Raster pixel transmitter: FIFO-buffered source, line gaps, sof/eol/eof
// markers and trailing all-ones pad lines to drain downstream windows.
module dark_stream_tx
  import dehaze_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int HBLANK      = 16,
  parameter int FLUSH_LINES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  pad_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int NROWS = IMG_HEIGHT + FLUSH_LINES;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int GW = (HBLANK > 0) ? $clog2(HBLANK + 1) : 1;
  localparam int IW = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_IMG_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_PAD_LAST = RW'(NROWS - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [IW-1:0] IN_MAX = IW'(TOTAL);
  localparam logic [DATA_WIDTH-1:0] PAD_PIX = PAD_MAX[DATA_WIDTH-1:0];

  tx_state_t             state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [GW-1:0]         gap;
  logic [IW-1:0]         in_cnt;
  logic                  fill;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_clr;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_rd;

  assign s_ready  = busy & ~fifo_full & (in_cnt < IN_MAX);
  assign push     = s_valid & s_ready;
  assign pop      = (state == S_ACTIVE) & ~fifo_empty;
  assign fifo_clr = (state == S_IDLE);

  pix_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (4)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fifo_clr),
    .push   (push),
    .pop    (pop),
    .wr_data(s_data),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Count accepted input pixels so the source is cut off after one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_cnt <= '0;
    else if (state == S_IDLE) in_cnt <= '0;
    else if (push) in_cnt <= in_cnt + 1'b1;
  end

  // Frame FSM with raster counters and the registered output stage.
  // fill masks the first ACTIVE cycle: s_ready only rises on entry, so
  // the FIFO is necessarily empty then and that is not a source underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      gap        <= '0;
      fill       <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      pad_out    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      pad_out    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ACTIVE;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            gap      <= '0;
            fill     <= 1'b1;
            underrun <= 1'b0;
          end
        end
        S_ACTIVE: begin
          fill <= 1'b0;
          if (fifo_empty) begin
            if (!fill) underrun <= 1'b1;
          end else begin
            valid_out <= 1'b1;
            data_out  <= fifo_rd;
            sof       <= (row == '0) && (col == '0);
            if (col == COL_LAST) begin
              eol <= 1'b1;
              col <= '0;
              if (row < ROW_IMG_LAST) begin
                row   <= row + 1'b1;
                gap   <= '0;
                state <= (HBLANK > 0) ? S_HGAP : S_ACTIVE;
              end else if (FLUSH_LINES > 0) begin
                row   <= row + 1'b1;
                state <= S_FLUSH;
              end else begin
                eof   <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_HGAP: begin
          if (gap == GAP_LAST) state <= S_ACTIVE;
          else gap <= gap + 1'b1;
        end
        S_FLUSH: begin
          valid_out <= 1'b1;
          data_out  <= PAD_PIX;
          pad_out   <= 1'b1;
          if (col == COL_LAST) begin
            eol <= 1'b1;
            col <= '0;
            if (row == ROW_PAD_LAST) begin
              eof   <= 1'b1;
              state <= S_DONE;
            end else begin
              row   <= row + 1'b1;
              gap   <= '0;
              state <= (HBLANK > 0) ? S_FGAP : S_FLUSH;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        S_FGAP: begin
          if (gap == GAP_LAST) state <= S_FLUSH;
          else gap <= gap + 1'b1;
        end
        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dark_stream_tx.sv
// Directed bench for dark_stream_tx: 4x3 frames with gaps and flush,
// stalls, ignored start, mid-frame reset, and a no-gap/no-flush build.
module tb_dark_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;

  logic       r0, v0, sof0, eol0, eof0, pad0, busy0, fd0, ur0;
  logic [7:0] d0;
  logic       r1, v1, sof1, eol1, eof1, pad1, busy1, fd1, ur1;
  logic [7:0] d1;

  logic       m_ready, m_valid, m_sof, m_eol, m_eof, m_pad;
  logic       m_busy, m_fd, m_ur;
  logic [7:0] m_data;

  int checks = 0;
  int failures = 0;

  logic [11:0] bq[$];
  int          bcyc[$];
  int          fd_cnt, fd_cyc, fd_busy, bad_mark, rdy_bad;

  always #5 clk = ~clk;

  dark_stream_tx #(
    .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3),
    .HBLANK(2), .FLUSH_LINES(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .start(start & ~sel), .s_valid(s_valid & ~sel), .s_data(s_data),
    .s_ready(r0), .valid_out(v0), .data_out(d0),
    .sof(sof0), .eol(eol0), .eof(eof0), .pad_out(pad0),
    .busy(busy0), .frame_done(fd0), .underrun(ur0)
  );

  dark_stream_tx #(
    .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3),
    .HBLANK(0), .FLUSH_LINES(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .start(start & sel), .s_valid(s_valid & sel), .s_data(s_data),
    .s_ready(r1), .valid_out(v1), .data_out(d1),
    .sof(sof1), .eol(eol1), .eof(eof1), .pad_out(pad1),
    .busy(busy1), .frame_done(fd1), .underrun(ur1)
  );

  assign m_ready = sel ? r1 : r0;
  assign m_valid = sel ? v1 : v0;
  assign m_data  = sel ? d1 : d0;
  assign m_sof   = sel ? sof1 : sof0;
  assign m_eol   = sel ? eol1 : eol0;
  assign m_eof   = sel ? eof1 : eof0;
  assign m_pad   = sel ? pad1 : pad0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_fd    = sel ? fd1 : fd0;
  assign m_ur    = sel ? ur1 : ur0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: source always valid; mode 1: valid every 3rd cycle.
  // start_at pulses start mid-frame; rst_at asserts reset and returns.
  task automatic run_frame(input int mode, input int start_at,
                           input int rst_at, input int budget);
    int pix;
    int xfers;
    bit stop;
    bq.delete();
    bcyc.delete();
    fd_cnt = 0; fd_cyc = -1; fd_busy = -1;
    bad_mark = 0; rdy_bad = 0;
    pix = 1; xfers = 0; stop = 1'b0;
    @(negedge clk);
    start = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget && !stop; cyc++) begin
      if (m_valid) begin
        bq.push_back({m_data, m_sof, m_eol, m_eof, m_pad});
        bcyc.push_back(cyc);
      end else if (m_sof | m_eol | m_eof | m_pad) begin
        bad_mark++;
      end
      if (m_fd) begin
        fd_cnt++;
        fd_cyc = cyc;
        fd_busy = int'(m_busy);
      end
      if (xfers >= 12 && m_ready) rdy_bad++;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        stop = 1'b1;
      end else if (fd_cnt > 0 && cyc >= fd_cyc + 4) begin
        stop = 1'b1;
      end else begin
        start = (cyc == start_at);
        s_valid = (mode == 0) || (cyc % 3 == 0);
        s_data = 8'(pix);
        if (s_valid && m_ready) begin
          pix++;
          xfers++;
        end
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_frame(input int n, input int hb, input bit timing,
                             input string nm);
    logic [11:0] e;
    chk({nm, "_beats"}, bq.size(), n);
    for (int i = 0; i < n && i < bq.size(); i++) begin
      e[11:4] = (i < 12) ? 8'(i + 1) : 8'hFF;
      e[3] = (i == 0);
      e[2] = (i % 4 == 3);
      e[1] = (i == n - 1);
      e[0] = (i >= 12);
      chk($sformatf("%s_beat%0d", nm, i), bq[i], e);
    end
    chk({nm, "_done_count"}, fd_cnt, 1);
    chk({nm, "_done_busy"}, fd_busy, 0);
    chk({nm, "_idle_markers"}, bad_mark, 0);
    chk({nm, "_ready_after_last"}, rdy_bad, 0);
    if (bq.size() == n) begin
      chk({nm, "_done_cycle"}, fd_cyc, bcyc[n-1] + 1);
      if (timing) begin
        for (int i = 1; i < 12; i++)
          chk($sformatf("%s_spacing%0d", nm, i), bcyc[i] - bcyc[i-1],
              (i % 4 == 0) ? hb + 1 : 1);
        for (int i = 13; i < n; i++)
          chk($sformatf("%s_pad_spacing%0d", nm, i),
              bcyc[i] - bcyc[i-1], 1);
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, m_valid, 0);
    chk({nm, "_data"}, m_data, 0);
    chk({nm, "_sof"}, m_sof, 0);
    chk({nm, "_eol"}, m_eol, 0);
    chk({nm, "_eof"}, m_eof, 0);
    chk({nm, "_pad"}, m_pad, 0);
    chk({nm, "_busy"}, m_busy, 0);
    chk({nm, "_done"}, m_fd, 0);
    chk({nm, "_underrun"}, m_ur, 0);
    chk({nm, "_ready"}, m_ready, 0);
  endtask

  initial begin
    int seen;
    sel = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    rst_n = 1'b0;

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, -1, -1, 200);
    check_frame(16, 2, 1'b1, "t1");
    chk("t1_underrun", m_ur, 0);
    chk("t1_ready_after_done", m_ready, 0);

    run_frame(1, -1, -1, 400);
    check_frame(16, 2, 1'b0, "t2");
    chk("t2_underrun", m_ur, 1);

    run_frame(0, 9, -1, 200);
    check_frame(16, 2, 1'b1, "t4");
    chk("t4_underrun", m_ur, 0);

    run_frame(0, -1, 10, 200);
    chk("t5_beats_before_reset", bq.size() >= 5 && bq.size() < 8, 1);
    #1;
    chk_all_zero("t5_in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_fd || m_valid || m_busy) seen++;
    end
    chk("t5_no_stale_activity", seen, 0);
    run_frame(0, -1, -1, 200);
    check_frame(16, 2, 1'b1, "t5");

    sel = 1'b1;
    @(negedge clk);
    run_frame(0, -1, -1, 200);
    check_frame(12, 0, 1'b1, "t6");
    chk("t6_underrun", m_ur, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
